lcd_rom_blit_ctrl: RTL

- Sequences reads from the 16-bit-wide, 17-bit-address image BlockROM.
- Fetches a rectangular sub-image (base, width, height, stride) and streams the pixels, in raster order, to the LCD pixel pipeline over a valid/ready interface.
- Hides the ROM's 1-cycle registered read latency with a credit-controlled 4-entry output FIFO.
- Sits between the game/sprite logic (start/config) and the LCD write path.

---
 rtl/lcd_rom_blit_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/lcd_rom_blit_ctrl.sv
// Rectangular blit engine: walks a sub-image in the image BlockROM and streams
// its pixels in raster order through a 4-entry credit-controlled output FIFO.
module lcd_rom_blit_ctrl #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 16,
  parameter int DIM_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [DIM_WIDTH-1:0]  img_w,
  input  logic [DIM_WIDTH-1:0]  img_h,
  input  logic [ADDR_WIDTH-1:0] stride,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_eol,
  output logic                  pix_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [DIM_WIDTH-1:0] DIM_ONE = DIM_WIDTH'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;

  state_t                  state, state_nxt;
  logic [DIM_WIDTH-1:0]    w_cfg, h_cfg, col, row;
  logic [ADDR_WIDTH-1:0]   stride_cfg, row_base;
  logic                    s1_valid, s1_eol, s1_last;
  logic                    s2_valid, s2_eol, s2_last;
  logic [DATA_WIDTH+1:0]   fifo_mem [4];
  logic [1:0]              wr_ptr, rd_ptr;
  logic [2:0]              fifo_count;

  logic                    pop, abort_act, start_act, zero_dims, finish, issue, credit_ok;
  logic [DIM_WIDTH-1:0]    cur_w, cur_h, cur_col, cur_row;
  logic [ADDR_WIDTH-1:0]   cur_base, cur_stride;
  logic                    cur_eol, cur_last;
  logic [1:0]              inflight;
  logic [3:0]              occupancy;
  logic [DATA_WIDTH+1:0]   head;

  // In IDLE the live config inputs stand in for the not-yet-latched registers
  always_comb begin
    if (state == IDLE) begin
      cur_w      = img_w;
      cur_h      = img_h;
      cur_col    = '0;
      cur_row    = '0;
      cur_base   = base_addr;
      cur_stride = stride;
    end else begin
      cur_w      = w_cfg;
      cur_h      = h_cfg;
      cur_col    = col;
      cur_row    = row;
      cur_base   = row_base;
      cur_stride = stride_cfg;
    end
  end

  assign head      = fifo_mem[rd_ptr];
  assign pix_valid = (fifo_count != 3'd0);
  assign pix_data  = pix_valid ? head[DATA_WIDTH+1:2] : '0;
  assign pix_eol   = pix_valid & head[1];
  assign pix_last  = pix_valid & head[0];
  assign pop       = pix_valid & pix_ready;
  assign abort_act = abort & (state != IDLE);
  assign start_act = start & (state == IDLE);
  assign zero_dims = (img_w == '0) || (img_h == '0);
  assign cur_eol   = (cur_col == cur_w - DIM_ONE);
  assign cur_last  = cur_eol && (cur_row == cur_h - DIM_ONE);
  assign finish    = (state == DRAIN) && !abort && pop && head[0];
  assign inflight  = {1'b0, s1_valid} + {1'b0, s2_valid};
  // Words already in the FIFO plus words still in the ROM pipeline must fit in 4
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight};
  assign credit_ok = occupancy <= (4'd3 + {3'b000, pop});

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (issue) state_nxt = cur_last ? DRAIN : FETCH;
        else       state_nxt = IDLE;
      end
      FETCH: begin
        if (abort)                  state_nxt = IDLE;
        else if (issue && cur_last) state_nxt = DRAIN;
        else                        state_nxt = FETCH;
      end
      DRAIN: begin
        if (abort || finish) state_nxt = IDLE;
        else                 state_nxt = DRAIN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: when a ROM address may be issued this cycle
  always_comb begin
    issue = 1'b0;
    case (state)
      IDLE: begin
        if (start && !zero_dims) issue = 1'b1;
        else                     issue = 1'b0;
      end
      FETCH: begin
        if (!abort && credit_ok) issue = 1'b1;
        else                     issue = 1'b0;
      end
      default: issue = 1'b0;
    endcase
  end

  // Config latch and raster address walker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_cfg      <= '0;
      h_cfg      <= '0;
      stride_cfg <= '0;
      col        <= '0;
      row        <= '0;
      row_base   <= '0;
      rom_addr   <= '0;
    end else begin
      if (start_act) begin
        w_cfg      <= img_w;
        h_cfg      <= img_h;
        stride_cfg <= stride;
      end
      if (issue) begin
        rom_addr <= cur_base + {{(ADDR_WIDTH-DIM_WIDTH){1'b0}}, cur_col};
        if (cur_eol) begin
          col      <= '0;
          row      <= cur_row + DIM_ONE;
          row_base <= cur_base + cur_stride;
        end else begin
          col      <= cur_col + DIM_ONE;
          row      <= cur_row;
          row_base <= cur_base;
        end
      end
    end
  end

  // Tag shadow pipeline matching the ROM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {s1_valid, s1_eol, s1_last} <= 3'b000;
      {s2_valid, s2_eol, s2_last} <= 3'b000;
    end else if (abort_act) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      {s1_valid, s1_eol, s1_last} <= {issue, cur_eol, cur_last};
      {s2_valid, s2_eol, s2_last} <= {s1_valid, s1_eol, s1_last};
    end
  end

  // Output FIFO; a write into an empty FIFO becomes visible the next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_count <= 3'd0;
    end else if (abort_act) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_count <= 3'd0;
    end else begin
      if (s2_valid) begin
        fifo_mem[wr_ptr] <= {rom_data, s2_eol, s2_last};
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      fifo_count <= fifo_count + {2'b00, s2_valid} - {2'b00, pop};
    end
  end

  // busy and done flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= (start_act && zero_dims) || finish;
      if (start_act && !zero_dims) busy <= 1'b1;
      else if (abort_act || finish) busy <= 1'b0;
    end
  end

endmodule
